regfile_dump_unit: RTL and testbench
====================================

// Module: regfile_dump_unit
// PURPOSE
//  Read-side initiator for the register file's rsel1/rdat1 port.
//  On a start pulse it walks register indices in ascending order and reads each one.
//  Each captured value is streamed as an (addr, data) beat over a valid/ready handshake.
//  Consumers are halt-time state dump logic and the testbench memory/regfile dumper.
// PARAMETERS
//  NREGS      32  number of registers walked (indices 0..NREGS-1)
//  DW         32  data width of rdat1/dump_data
//  SKIP_ZERO  0   1: begin at index 1, never emit register 0
// PORTS
//  CLK         in   1       rising-edge clock
//  RST         in   1       synchronous, active-high reset
//  start       in   1       one-cycle request to begin a dump
//  rsel1       out  5       read select driven into register file
//  rdat1       in   DW      combinational read data from register file
//  dump_valid  out  1       beat valid
//  dump_ready  in   1       consumer accepts beat
//  dump_addr   out  5       register index of current beat
//  dump_data   out  DW      captured register value of current beat
//  busy        out  1       high from accept of start until done
//  done        out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
//  - Reset (RST high at edge), from any state:
//    - state=IDLE, idx=0, rsel1=0, dump_valid=0, dump_addr=0, dump_data=0, busy=0, done=0.
//    - Reset mid-dump abandons the dump; no done pulse is produced.
//  - FSM states: IDLE, READ, SEND, DONE.
//  - IDLE:
//    - rsel1=0.
//    - start=1 -> READ, with idx = SKIP_ZERO ? 1 : 0, and busy=1 from the next cycle.
//  - READ (exactly one cycle):
//    - rsel1=idx.
//    - At the edge: dump_data<=rdat1, dump_addr<=idx, state->SEND.
//  - SEND:
//    - dump_valid=1; dump_addr and dump_data are held stable until accepted.
//    - Beat transfers on an edge where dump_valid && dump_ready.
//    - On transfer, if idx==NREGS-1 -> DONE; else idx<=idx+1 -> READ.
//    - dump_valid falls the cycle after transfer; no back-to-back beats.
//  - DONE (one cycle): done=1, busy=1 -> IDLE. busy=0 in IDLE.
//  - start is ignored while busy (READ/SEND/DONE); no queuing.
//  - Data is captured, not live: a regfile write to idx during SEND does not change dump_data.
//  - A write to idx landing on the same edge as READ returns the pre-write value
//    (the register file updates on that edge).
//  - rsel1 is driven only by this block; the read is purely combinational (0-cycle latency).
//  - Throughput: 1 beat per 2 cycles with dump_ready held high.
//  - Full dump, ready high: start edge to done pulse = 2*N+1 cycles, N = beats emitted.
//  - Backpressure stalls indefinitely in SEND; no timeout.
//  - idx wrap: never increments past NREGS-1; the dump ends there.
//  - Register 0 reads 0 by regfile design; it is emitted as data 0 unless SKIP_ZERO=1.
// TESTING
//  1 Preload reg k = 0x1000+k, start pulse, dump_ready=1
//    -> 32 beats, addr 0..31, data 0 then 0x1001..0x101F;
//    done exactly 65 cycles after start edge.
//  2 Same preload, dump_ready toggling 1-of-3 cycles
//    -> identical beat sequence; addr/data stable while valid && !ready; single done.
//  3 SKIP_ZERO=1, same preload
//    -> 31 beats, first beat addr 1 / data 0x1001, last beat addr 31 / data 0x101F.
//  4 Hold ready=0 at beat addr 5; write reg5=0xDEAD
//    -> dump_data stays 0x1005 until accepted; the next dump shows 0xDEAD.
//  5 Second start pulse during beat 10 -> ignored; only one done; busy stays 1 throughout.
//  6 Assert RST during SEND of beat 7
//    -> next cycle valid=0, busy=0, done never pulses;
//    a fresh start then dumps from addr 0.

Source files
------------

// File: rtl/regfile_dump_unit_if.sv
// Purpose : register-file read port plus (addr, data) dump beat stream.
// Latency : n/a (wires only); the regfile read is combinational.
// Backpr. : dump_ready from the consumer stalls the beat in place.
// Ports   : rsel1/rdat1 regfile read select and data; dump_valid/dump_ready handshake;
//           dump_addr/dump_data beat payload.
//           master = dump unit side, slave = regfile + consumer side.
interface regfile_dump_unit_if #(
  parameter int DW = 32
);
  logic [4:0]    rsel1;
  logic [DW-1:0] rdat1;
  logic          dump_valid;
  logic          dump_ready;
  logic [4:0]    dump_addr;
  logic [DW-1:0] dump_data;

  modport master (
    output rsel1,
    input  rdat1,
    output dump_valid,
    input  dump_ready,
    output dump_addr,
    output dump_data
  );

  modport slave (
    input  rsel1,
    output rdat1,
    input  dump_valid,
    output dump_ready,
    input  dump_addr,
    input  dump_data
  );
endinterface

// File: rtl/regfile_dump_unit.sv
// Purpose : on start, read registers in ascending order and stream each as an (addr, data) beat.
// Latency : 2 cycles per beat (READ + SEND); start edge to done pulse is 2*N+1 cycles.
// Backpr. : a beat waits in SEND with addr/data held until dump_ready; no timeout.
// Ports   : CLK, RST (sync, active-high); start request; dif = regfile read port and
//           dump stream (master modport); busy from accepted start to done; done pulse.
module regfile_dump_unit #(
  parameter int NREGS     = 32,
  parameter int DW        = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  regfile_dump_unit_if.master  dif,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam logic [4:0] FIRST_IDX = SKIP_ZERO ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST_IDX  = 5'(NREGS - 1);

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic [4:0]    rsel1_c;
  logic          dump_valid_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      addr_q  <= 5'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rsel1_c      = 5'd0;
    dump_valid_c = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = ST_READ;
        end
      end

      // The regfile answers combinationally, so the value is captured on the
      // same edge. A write landing on that edge is not yet visible here.
      ST_READ: begin
        rsel1_c = idx_q;
        data_d  = dif.rdat1;
        addr_d  = idx_q;
        state_d = ST_SEND;
      end

      // Payload comes from the capture flops, so later regfile writes to this
      // index cannot disturb a stalled beat.
      ST_SEND: begin
        dump_valid_c = 1'b1;
        if (dif.dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_READ;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dif.rsel1      = rsel1_c;
  assign dif.dump_valid = dump_valid_c;
  assign dif.dump_addr  = addr_q;
  assign dif.dump_data  = data_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
module tb_regfile_dump_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;

  regfile_dump_unit_if #(.DW(32)) if_a ();
  regfile_dump_unit_if #(.DW(32)) if_b ();

  // Behavioural register file: register 0 is hard-wired to zero.
  logic [31:0] regs [32];
  assign if_a.rdat1 = (if_a.rsel1 == 5'd0) ? 32'd0 : regs[if_a.rsel1];
  assign if_b.rdat1 = (if_b.rsel1 == 5'd0) ? 32'd0 : regs[if_b.rsel1];

  regfile_dump_unit #(.NREGS(32), .DW(32), .SKIP_ZERO(1'b0)) dut_a (
    .CLK(CLK), .RST(RST), .start(start_a), .dif(if_a), .busy(busy_a), .done(done_a)
  );

  regfile_dump_unit #(.NREGS(32), .DW(32), .SKIP_ZERO(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .dif(if_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } beat_t;

  // Scoreboard state for instance A
  beat_t       q_a[$];
  int          exp_dones_a = 0;
  int          start_cyc_a = 0;
  bit          arm_a = 0, in_dump_a = 0, chk_idle_a = 0, lat_chk_a = 0;
  bit          prev_stall_a = 0, prev_xfer_a = 0;
  logic [4:0]  prev_addr_a;
  logic [31:0] prev_data_a;

  // Scoreboard state for instance B (SKIP_ZERO)
  beat_t       q_b[$];
  int          exp_dones_b = 0;
  int          start_cyc_b = 0;

  // Ready policy for instance A: 0 always, 1 one-in-three, 2 stall at an address, 3 random
  int          mode_a = 0;
  int          stall_addr = 0, stall_len = 0, stall_cnt = 0;

  initial begin
    if_a.dump_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (mode_a)
        0: if_a.dump_ready = 1'b1;
        1: if_a.dump_ready = (cyc % 3 == 0);
        2: begin
          if (if_a.dump_valid && if_a.dump_addr == 5'(stall_addr) && stall_cnt < stall_len) begin
            if_a.dump_ready = 1'b0;
            stall_cnt++;
          end else begin
            if_a.dump_ready = 1'b1;
          end
        end
        default: if_a.dump_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial if_b.dump_ready = 1'b1;

  // Reference model: a dump is the list of registers from the first index to
  // the last, each paired with its contents at the moment the dump starts.
  task automatic issue_start_a();
    @(negedge CLK);
    if (exp_dones_a == 0) begin
      for (int k = 0; k < 32; k++) q_a.push_back('{a: 5'(k), d: (k == 0) ? 32'd0 : regs[k]});
      exp_dones_a++;
      start_cyc_a = cyc;
      arm_a = 1'b1;
    end
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
  endtask

  task automatic issue_start_b();
    @(negedge CLK);
    for (int k = 1; k < 32; k++) q_b.push_back('{a: 5'(k), d: regs[k]});
    exp_dones_b++;
    start_cyc_b = cyc;
    start_b = 1'b1;
    @(negedge CLK);
    start_b = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((busy_a || exp_dones_a != 0) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("dump_a_completes_in_budget", (n < 3000), 1'b1);
  endtask

  task automatic wait_beat_a(input int addr);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 3000) begin
      @(negedge CLK);
      n++;
      if (if_a.dump_valid && if_a.dump_addr == 5'(addr)) seen = 1;
    end
    chk("beat_a_reached", seen, 1'b1);
  endtask

  // Monitor A: pops the scoreboard on each transfer and checks protocol rules.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (arm_a && cyc > start_cyc_a) begin
          in_dump_a = 1'b1;
          arm_a = 1'b0;
        end
        if (in_dump_a) chk("busy_a_during_dump", busy_a, 1'b1);
        if (chk_idle_a) begin
          chk("busy_a_after_done", busy_a, 1'b0);
          chk_idle_a = 1'b0;
        end
        if (prev_xfer_a) chk("valid_a_gap_after_transfer", if_a.dump_valid, 1'b0);
        if (prev_stall_a) begin
          chk("addr_a_stable_while_stalled", if_a.dump_addr, prev_addr_a);
          chk("data_a_stable_while_stalled", if_a.dump_data, prev_data_a);
        end
        prev_stall_a = if_a.dump_valid && !if_a.dump_ready;
        prev_xfer_a  = if_a.dump_valid && if_a.dump_ready;
        prev_addr_a  = if_a.dump_addr;
        prev_data_a  = if_a.dump_data;
        if (if_a.dump_valid && if_a.dump_ready) begin
          if (q_a.size() == 0) begin
            chk("beat_a_unexpected", 1'b1, 1'b0);
          end else begin
            beat_t e;
            e = q_a.pop_front();
            chk("beat_a_addr", if_a.dump_addr, e.a);
            chk("beat_a_data", if_a.dump_data, e.d);
          end
        end
        if (done_a) begin
          chk("done_a_expected", (exp_dones_a > 0), 1'b1);
          chk("done_a_all_beats_sent", q_a.size(), 0);
          if (lat_chk_a) chk("done_a_latency", cyc - start_cyc_a, 65);
          if (exp_dones_a > 0) exp_dones_a--;
          in_dump_a  = 1'b0;
          chk_idle_a = 1'b1;
        end
      end
    end
  end

  // Monitor B
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (if_b.dump_valid && if_b.dump_ready) begin
          if (q_b.size() == 0) begin
            chk("beat_b_unexpected", 1'b1, 1'b0);
          end else begin
            beat_t e;
            e = q_b.pop_front();
            chk("beat_b_addr", if_b.dump_addr, e.a);
            chk("beat_b_data", if_b.dump_data, e.d);
          end
        end
        if (done_b) begin
          chk("done_b_expected", (exp_dones_b > 0), 1'b1);
          chk("done_b_all_beats_sent", q_b.size(), 0);
          chk("done_b_latency", cyc - start_cyc_b, 63);
          if (exp_dones_b > 0) exp_dones_b--;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000 + 32'(k);
    regs[0] = 32'd0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_rsel1", if_a.rsel1, 5'd0);
    chk("rst_valid", if_a.dump_valid, 1'b0);
    chk("rst_addr", if_a.dump_addr, 5'd0);
    chk("rst_data", if_a.dump_data, 32'd0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_valid_b", if_b.dump_valid, 1'b0);
    @(posedge CLK);
    #2 RST = 1'b0;

    // 1: full dump, ready held high
    mode_a = 0; lat_chk_a = 1;
    issue_start_a();
    wait_idle_a();

    // 2: ready one cycle in three
    mode_a = 1; lat_chk_a = 0;
    issue_start_a();
    wait_idle_a();

    // 3: SKIP_ZERO instance
    issue_start_b();
    begin
      int n = 0;
      while (exp_dones_b != 0 && n < 3000) begin
        @(negedge CLK);
        n++;
      end
      chk("dump_b_completes_in_budget", (n < 3000), 1'b1);
    end

    // 4: stall at addr 5, overwrite reg 5, data must hold the captured value
    mode_a = 2; stall_addr = 5; stall_len = 8; stall_cnt = 0; lat_chk_a = 0;
    issue_start_a();
    wait_beat_a(5);
    regs[5] = 32'hDEAD;
    repeat (3) @(negedge CLK);
    chk("stalled_valid", if_a.dump_valid, 1'b1);
    chk("stalled_data_captured", if_a.dump_data, 32'h1005);
    wait_idle_a();
    mode_a = 0; lat_chk_a = 1;
    issue_start_a();
    wait_idle_a();

    // 5: second start during beat 10 is ignored
    issue_start_a();
    wait_beat_a(10);
    issue_start_a();
    wait_idle_a();
    repeat (4) @(negedge CLK);
    chk("no_extra_dump_after_ignored_start", busy_a, 1'b0);

    // 6: reset during SEND of beat 7
    mode_a = 2; stall_addr = 7; stall_len = 1000; stall_cnt = 0; lat_chk_a = 0;
    issue_start_a();
    wait_beat_a(7);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    q_a.delete();
    exp_dones_a = 0; in_dump_a = 0; arm_a = 0; chk_idle_a = 0;
    prev_stall_a = 0; prev_xfer_a = 0;
    @(posedge CLK);
    #2;
    chk("reset_mid_valid", if_a.dump_valid, 1'b0);
    chk("reset_mid_busy", busy_a, 1'b0);
    chk("reset_mid_done", done_a, 1'b0);
    chk("reset_mid_addr", if_a.dump_addr, 5'd0);
    RST = 1'b0;
    mode_a = 0;
    repeat (10) @(negedge CLK);
    lat_chk_a = 1;
    issue_start_a();
    wait_idle_a();

    // Randomized contents and random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k < 32; k++) regs[k] = $urandom;
      mode_a = 3; lat_chk_a = 0;
      issue_start_a();
      wait_idle_a();
    end

    repeat (4) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
